mdu_ctrl: RTL and testbench



---
 rtl/mdu_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/divide sequencer for the EX stage.
// Decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO, runs a 1-bit-per-cycle
// shift-add multiplier or restoring divider, and owns the HI/LO registers.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   EX_valid            EX holds a real instruction
//   EX_op, EX_func      instruction opcode / func fields
//   EX_busA, EX_busB    rs / rt operands (forwarded)
//   cancel              flush; aborts any operation in progress
//   stall               combinational hold request to the hazard logic
//   busy                sequencer not idle
//   done                one-cycle pulse after HI/LO written by mult/div
//   HI, LO              result registers
//   EX_MULT_result      {HI, LO}
//   md_rdata            HI for MFHI, else LO (combinational)
module mdu_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 EX_valid,
  input  logic [5:0]           EX_op,
  input  logic [5:0]           EX_func,
  input  logic [WIDTH-1:0]     EX_busA,
  input  logic [WIDTH-1:0]     EX_busB,
  input  logic                 cancel,
  output logic                 stall,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     HI,
  output logic [WIDTH-1:0]     LO,
  output logic [2*WIDTH-1:0]   EX_MULT_result,
  output logic [WIDTH-1:0]     md_rdata
);

  localparam int unsigned ACC_W = 2 * WIDTH;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;       // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [CNT_W-1:0]   cnt;
  logic               sign_a;
  logic               sign_b;
  logic               op_div;
  logic               div_zero;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Instruction decode
  logic dec, is_mult, is_multu, is_div, is_divu, is_mfhi, is_mthi, is_mflo, is_mtlo;
  logic md_class, start_mul, start_div, op_signed;

  always_comb begin
    dec       = EX_valid && (EX_op == 6'd0);
    is_mult   = dec && (EX_func == F_MULT);
    is_multu  = dec && (EX_func == F_MULTU);
    is_div    = dec && (EX_func == F_DIV);
    is_divu   = dec && (EX_func == F_DIVU);
    is_mfhi   = dec && (EX_func == F_MFHI);
    is_mthi   = dec && (EX_func == F_MTHI);
    is_mflo   = dec && (EX_func == F_MFLO);
    is_mtlo   = dec && (EX_func == F_MTLO);
    md_class  = is_mult | is_multu | is_div | is_divu | is_mfhi | is_mthi | is_mflo | is_mtlo;
    start_mul = is_mult | is_multu;
    start_div = is_div | is_divu;
    op_signed = is_mult | is_div;
  end

  // Operand magnitudes for signed ops
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             a_neg, b_neg;

  always_comb begin
    a_neg = op_signed & EX_busA[WIDTH-1];
    b_neg = op_signed & EX_busB[WIDTH-1];
    a_abs = a_neg ? (WIDTH'(0) - EX_busA) : EX_busA;
    b_abs = b_neg ? (WIDTH'(0) - EX_busB) : EX_busB;
  end

  // One shift-add multiply step
  logic [WIDTH:0]   mul_sum;
  logic [ACC_W-1:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // One restoring divide step; the difference always fits in WIDTH bits when taken
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [ACC_W-1:0] div_next;

  always_comb begin
    div_sh   = {acc[ACC_W-1:WIDTH], acc[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opnd});
    div_diff = div_sh[WIDTH-1:0] - opnd;
    div_next = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                      : {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Sign fix-up of the final unsigned result
  logic             neg_res;
  logic [ACC_W-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    neg_res  = sign_a ^ sign_b;
    prod_fix = neg_res ? (ACC_W'(0) - acc) : acc;
    quo_fix  = neg_res ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix  = sign_a ? (WIDTH'(0) - acc[ACC_W-1:WIDTH]) : acc[ACC_W-1:WIDTH];
  end

  // Sequencer and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      op_div   <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!cancel) begin
            if (start_mul) begin
              state    <= MUL;
              busy     <= 1'b1;
              cnt      <= '0;
              opnd     <= a_abs;
              acc      <= {WIDTH'(0), b_abs};
              sign_a   <= a_neg;
              sign_b   <= b_neg;
              op_div   <= 1'b0;
              div_zero <= 1'b0;
            end else if (start_div) begin
              busy     <= 1'b1;
              cnt      <= '0;
              opnd     <= b_abs;
              sign_a   <= a_neg;
              sign_b   <= b_neg;
              op_div   <= 1'b1;
              if (EX_busB == WIDTH'(0)) begin
                // Divide by zero: skip iteration, FIX writes {busA, all-ones}
                state    <= FIX;
                div_zero <= 1'b1;
                acc      <= {EX_busA, {WIDTH{1'b1}}};
              end else begin
                state    <= DIV;
                div_zero <= 1'b0;
                acc      <= {WIDTH'(0), a_abs};
              end
            end else if (is_mthi) begin
              hi_q <= EX_busA;
            end else if (is_mtlo) begin
              lo_q <= EX_busA;
            end
          end
        end
        MUL, DIV: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= (state == MUL) ? mul_next : div_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_ITER) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!cancel) begin
            done <= 1'b1;
            if (div_zero) begin
              hi_q <= acc[ACC_W-1:WIDTH];
              lo_q <= acc[WIDTH-1:0];
            end else if (op_div) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[ACC_W-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign HI             = hi_q;
  assign LO             = lo_q;
  assign EX_MULT_result = {hi_q, lo_q};
  assign md_rdata       = is_mfhi ? hi_q : lo_q;
  assign stall          = EX_valid & md_class & (state != IDLE);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: table-driven mult/div vectors with a
// result scoreboard, plus hand-written hazard, cancel and reset sequences.
module tb_mdu_ctrl;

  localparam int unsigned WIDTH = 32;

  logic               clk;
  logic               rst_n;
  logic               EX_valid;
  logic [5:0]         EX_op;
  logic [5:0]         EX_func;
  logic [WIDTH-1:0]   EX_busA;
  logic [WIDTH-1:0]   EX_busB;
  logic               cancel;
  logic               stall;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   HI;
  logic [WIDTH-1:0]   LO;
  logic [2*WIDTH-1:0] EX_MULT_result;
  logic [WIDTH-1:0]   md_rdata;

  mdu_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .EX_valid       (EX_valid),
    .EX_op          (EX_op),
    .EX_func        (EX_func),
    .EX_busA        (EX_busA),
    .EX_busB        (EX_busB),
    .cancel         (cancel),
    .stall          (stall),
    .busy           (busy),
    .done           (done),
    .HI             (HI),
    .LO             (LO),
    .EX_MULT_result (EX_MULT_result),
    .md_rdata       (md_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one instruction for a single EX cycle
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    EX_valid = 1'b1; EX_op = 6'd0; EX_func = f; EX_busA = a; EX_busB = b;
    @(posedge clk);
    #1;
    EX_valid = 1'b0; EX_func = 6'd0;
  endtask

  // Wait for done, counting busy cycles; bounded
  task automatic wait_done(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) lat++;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic finish_check(input string name, input int exp_lat);
    int          lat;
    bit          ok;
    logic [63:0] exp;
    wait_done(lat, ok);
    chk({name, "_done_seen"}, 64'(ok), 64'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    if (ok) begin
      chk({name, "_hi"}, 64'(HI), 64'(exp[63:32]));
      chk({name, "_lo"}, 64'(LO), 64'(exp[31:0]));
      chk({name, "_result"}, EX_MULT_result, exp);
      chk({name, "_busy_cycles"}, 64'(lat), 64'(exp_lat));
      @(negedge clk);
      chk({name, "_done_single"}, 64'(done), 64'd0);
    end
  endtask

  vec_t vecs[10];

  initial begin
    int n_stall, n_iter, n_done;
    bit ok;

    vecs[0] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[1] = '{F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
    vecs[2] = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
    vecs[3] = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[4] = '{F_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 33};
    vecs[5] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[6] = '{F_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1};
    vecs[7] = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[8] = '{F_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33};
    vecs[9] = '{F_MULTU, 32'h00012345, 32'h00010000, 32'h00000001, 32'h23450000, 33};

    rst_n = 1'b0; EX_valid = 1'b0; EX_op = 6'd0; EX_func = 6'd0;
    EX_busA = '0; EX_busB = '0; cancel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", EX_MULT_result, 64'd0);
    rst_n = 1'b1;

    // Table-driven mult/div vectors
    for (int i = 0; i < 10; i++) begin
      sb.push_back({vecs[i].hi, vecs[i].lo});
      issue(vecs[i].f, vecs[i].a, vecs[i].b);
      finish_check($sformatf("vec%0d", i), vecs[i].lat);
    end

    // MULT, then ADD flows past, then MFLO stalls until done
    sb.push_back({32'd0, 32'd15});
    @(negedge clk);
    EX_valid = 1'b1; EX_op = 6'd0; EX_func = F_MULT; EX_busA = 32'd3; EX_busB = 32'd5;
    @(posedge clk); #1;
    EX_func = F_ADD;
    @(negedge clk);
    chk("add_stall", 64'(stall), 64'd0);
    chk("add_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    EX_func = F_MFLO;
    n_stall = 0; n_iter = 0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
      n_iter++;
      if (stall) n_stall++;
    end
    chk("mflo_done_seen", 64'(ok), 64'd1);
    chk("mflo_stall_cycles", 64'(n_stall), 64'd32);
    chk("mflo_wait_cycles", 64'(n_iter), 64'd32);
    chk("mflo_stall_after", 64'(stall), 64'd0);
    chk("mflo_rdata", 64'(md_rdata), 64'(sb.pop_front()));
    @(posedge clk); #1;
    EX_func = F_MTHI; EX_busA = 32'h1234;
    @(negedge clk);
    chk("mthi_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    EX_func = F_MFHI;
    @(negedge clk);
    chk("mthi_hi", 64'(HI), 64'h1234);
    chk("mfhi_rdata", 64'(md_rdata), 64'h1234);
    chk("mthi_lo_kept", 64'(LO), 64'd15);
    EX_valid = 1'b0;

    // Cancel at E10 of a DIV
    issue(F_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_hi", 64'(HI), 64'h1234);
    chk("cancel_lo", 64'(LO), 64'd15);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("cancel_no_done", 64'(n_done), 64'd0);

    // Cancel together with MULT / MTLO decoded in IDLE
    @(negedge clk);
    EX_valid = 1'b1; EX_func = F_MULT; EX_busA = 32'd2; EX_busB = 32'd3; cancel = 1'b1;
    @(posedge clk); #1;
    EX_func = F_MTLO; EX_busA = 32'hDEAD;
    @(negedge clk);
    chk("cancel_start_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    EX_valid = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("cancel_mtlo_lo", 64'(LO), 64'd15);
    chk("cancel_start_busy2", 64'(busy), 64'd0);

    // Reset mid-MUL
    issue(F_MULT, 32'd3, 32'd5);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_result", EX_MULT_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery after reset
    sb.push_back({32'd0, 32'd42});
    issue(F_MULTU, 32'd6, 32'd7);
    finish_check("post_rst", 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
